capture_controller: RTL and testbench
=====================================

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 Parameter NUM_CHANNELS, default 16, SHALL set the number of sampled channels.
REQ-002 Parameter ADDR_BITS, default 10, SHALL set the capture buffer depth to 2^ADDR_BITS.
REQ-003 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high.
REQ-005 arm  input  1  SHALL be a one-cycle capture start request.
REQ-006 abort  input  1  SHALL be a one-cycle capture cancel request.
REQ-007 sampleTick  input  1  SHALL qualify the cycles on which chanSignals is sampled.
REQ-008 chanSignals  input  NUM_CHANNELS  SHALL carry the channel values being captured.
REQ-009 trigMask  input  NUM_CHANNELS  SHALL select the channels compared for trigger (1 = compared).
REQ-010 trigValue  input  NUM_CHANNELS  SHALL give the required level of each compared channel.
REQ-011 preCount  input  ADDR_BITS  SHALL give the number of pre-trigger samples.
REQ-012 postCount  input  ADDR_BITS  SHALL give the number of samples after the trigger sample.
REQ-013 wrEn  output  1  SHALL be the buffer write strobe.
REQ-014 wrAddr  output  ADDR_BITS  SHALL be the buffer write address.
REQ-015 wrData  output  NUM_CHANNELS  SHALL be the buffer write data.
REQ-016 trigAddr  output  ADDR_BITS  SHALL hold the address of the trigger sample.
REQ-017 busy  output  1  SHALL be high in PRETRIG, WAIT_TRIG, POSTTRIG.
REQ-018 done  output  1  SHALL be high in DONE.
REQ-019 state  output  3  SHALL expose the state encoding: IDLE=0, PRETRIG=1, WAIT_TRIG=2, POSTTRIG=3, DONE=4.

Function
REQ-020 States SHALL be IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE; all outputs registered.
REQ-021 arm in IDLE or DONE SHALL latch preCount/postCount, clear the write address to 0, and enter PRETRIG (preCount>0) or WAIT_TRIG (preCount=0); arm in busy states SHALL be ignored.
REQ-022 In any busy state, a cycle with sampleTick=1 SHALL, one cycle later, give wrEn=1 for exactly one cycle, wrData = chanSignals sampled at that edge, wrAddr = current address; the address then increments modulo 2^ADDR_BITS.
REQ-023 No write SHALL occur in IDLE or DONE, nor in cycles with sampleTick=0.
REQ-024 PRETRIG: each sampled cycle decrements the latched pre-count; the sample bringing it to 0 SHALL move the FSM to WAIT_TRIG; PRETRIG samples SHALL never trigger.
REQ-025 Trigger match SHALL be ((chanSignals XOR trigValue) AND trigMask) == 0, evaluated only on sampled cycles in WAIT_TRIG; trigMask = 0 SHALL match on the first sample.
REQ-026 On a match the sample SHALL still be written, trigAddr SHALL load its address, and the FSM SHALL enter POSTTRIG (postCount>0) or DONE (postCount=0).
REQ-027 POSTTRIG: each sampled cycle decrements the latched post-count; the sample bringing it to 0 SHALL be written and the FSM SHALL enter DONE.
REQ-028 Non-matching WAIT_TRIG samples SHALL keep writing, wrapping the address and overwriting oldest data without limit.
REQ-029 If preCount+postCount+1 > 2^ADDR_BITS, oldest pre-trigger samples SHALL be silently overwritten; no error flag.
REQ-030 abort in any busy state SHALL return to IDLE on the next edge, suppress any write for that cycle, and leave trigAddr unchanged; abort in IDLE/DONE SHALL have no effect.
REQ-031 arm and abort in the same cycle: abort SHALL win; from IDLE/DONE the FSM SHALL enter IDLE.
REQ-032 DONE SHALL hold until arm (restart) or abort (to IDLE).

Reset
REQ-033 reset high SHALL asynchronously force state=IDLE and wrEn, wrAddr, wrData, trigAddr, busy, done, and internal counters to 0, including mid-capture.
REQ-034 After reset release, no write SHALL occur until an arm is accepted.

Verification
REQ-035 preCount=4, postCount=3, trigMask=0x0001, trigValue=0x0001, counting input, sampleTick every cycle -> 4 PRETRIG writes at 0..3, trigger at first odd sample, trigAddr = its address, exactly 3 further writes, done=1.
REQ-036 preCount=0, postCount=0, trigMask=0 -> single write at address 0, trigAddr=0, DONE on the following edge.
REQ-037 ADDR_BITS=3, trigger never matches, 20 ticks -> wrAddr wraps 7->0, state stays WAIT_TRIG, busy=1.
REQ-038 sampleTick every 4th cycle -> wrEn only on the cycle after each tick, counts advance only on ticks.
REQ-039 abort in POSTTRIG simultaneous with sampleTick -> no write, state=IDLE next cycle; arm+abort in DONE -> IDLE.
REQ-040 reset asserted mid-POSTTRIG between clock edges -> outputs 0 immediately, no further wrEn until re-armed.

Source files
------------

// File: rtl/capture_controller.sv
// rtl/capture_controller.sv - triggered sample capture controller for a circular buffer
//
// Purpose:
//   Samples chanSignals on qualified cycles and writes each sample into a
//   circular capture buffer of 2^ADDR_BITS entries. A capture collects a
//   programmable number of pre-trigger samples, waits for a masked level
//   match, records the address of the trigger sample, then collects a
//   programmable number of post-trigger samples before stopping.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   arm          one-cycle capture start (ignored while busy)
//   abort        one-cycle capture cancel (wins over arm)
//   sampleTick   qualifies the cycles on which chanSignals is sampled
//   chanSignals  channel values being captured
//   trigMask     channels compared for trigger (1 = compared)
//   trigValue    required level of each compared channel
//   preCount     number of pre-trigger samples, latched on arm
//   postCount    number of samples after the trigger sample, latched on arm
//   wrEn         buffer write strobe (one cycle per sample)
//   wrAddr       buffer write address
//   wrData       buffer write data
//   trigAddr     address of the trigger sample
//   busy         high in PRETRIG, WAIT_TRIG, POSTTRIG
//   done         high in DONE
//   state        IDLE=0, PRETRIG=1, WAIT_TRIG=2, POSTTRIG=3, DONE=4

module capture_controller #(
  parameter int NUM_CHANNELS = 16,
  parameter int ADDR_BITS    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    sampleTick,
  input  logic [NUM_CHANNELS-1:0] chanSignals,
  input  logic [NUM_CHANNELS-1:0] trigMask,
  input  logic [NUM_CHANNELS-1:0] trigValue,
  input  logic [ADDR_BITS-1:0]    preCount,
  input  logic [ADDR_BITS-1:0]    postCount,
  output logic                    wrEn,
  output logic [ADDR_BITS-1:0]    wrAddr,
  output logic [NUM_CHANNELS-1:0] wrData,
  output logic [ADDR_BITS-1:0]    trigAddr,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRETRIG   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POSTTRIG  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t                  state_q, state_n;
  logic [ADDR_BITS-1:0]    addr_q, addr_n;       // next buffer slot to write
  logic [ADDR_BITS-1:0]    pre_q, pre_n;         // remaining pre-trigger samples
  logic [ADDR_BITS-1:0]    post_q, post_n;       // remaining post-trigger samples
  logic [ADDR_BITS-1:0]    trig_q, trig_n;
  logic                    wr_en_q, wr_en_n;
  logic [ADDR_BITS-1:0]    wr_addr_q, wr_addr_n;
  logic [NUM_CHANNELS-1:0] wr_data_q, wr_data_n;
  logic                    busy_q, busy_n;
  logic                    done_q, done_n;
  logic                    trig_match;

  // Unmasked channels are don't-care, so an all-zero mask matches anything.
  assign trig_match = ((chanSignals ^ trigValue) & trigMask) == '0;

  // Next-state and next-output logic. Every output is a register, so the
  // write strobe for a sampled cycle appears on the following cycle.
  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    pre_n     = pre_q;
    post_n    = post_q;
    trig_n    = trig_q;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          // Abort beats a simultaneous arm; from DONE it also returns to IDLE.
          state_n = ST_IDLE;
        end else if (arm) begin
          pre_n     = preCount;
          post_n    = postCount;
          addr_n    = '0;
          wr_addr_n = '0;
          state_n   = (preCount != '0) ? ST_PRETRIG : ST_WAIT_TRIG;
        end
      end

      ST_PRETRIG, ST_WAIT_TRIG, ST_POSTTRIG: begin
        if (abort) begin
          // Drop the sample of this cycle and keep the last trigger address.
          state_n = ST_IDLE;
        end else if (sampleTick) begin
          wr_en_n   = 1'b1;
          wr_addr_n = addr_q;
          wr_data_n = chanSignals;
          addr_n    = addr_q + ADDR_BITS'(1);   // wraps, overwriting oldest data

          case (state_q)
            ST_PRETRIG: begin
              // Counter is nonzero on entry, so reaching 1 means this is the last one.
              pre_n = pre_q - ADDR_BITS'(1);
              if (pre_q == ADDR_BITS'(1)) begin
                state_n = ST_WAIT_TRIG;
              end
            end
            ST_WAIT_TRIG: begin
              if (trig_match) begin
                trig_n  = addr_q;
                state_n = (post_q != '0) ? ST_POSTTRIG : ST_DONE;
              end
            end
            ST_POSTTRIG: begin
              post_n = post_q - ADDR_BITS'(1);
              if (post_q == ADDR_BITS'(1)) begin
                state_n = ST_DONE;
              end
            end
            default: begin
              state_n = ST_IDLE;
            end
          endcase
        end
      end

      default: begin
        // Unused encodings recover to IDLE.
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n == ST_PRETRIG) || (state_n == ST_WAIT_TRIG) ||
             (state_n == ST_POSTTRIG);
    done_n = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      trig_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      addr_q    <= addr_n;
      pre_q     <= pre_n;
      post_q    <= post_n;
      trig_q    <= trig_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  assign wrEn     = wr_en_q;
  assign wrAddr   = wr_addr_q;
  assign wrData   = wr_data_q;
  assign trigAddr = trig_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: tb/tb_capture_controller.sv
// tb/tb_capture_controller.sv - table-driven bench for capture_controller

module tb_capture_controller;

  localparam int NC = 16;
  localparam int AB = 3;

  logic          clk;
  logic          reset;
  logic          arm;
  logic          abort;
  logic          sampleTick;
  logic [NC-1:0] chanSignals;
  logic [NC-1:0] trigMask;
  logic [NC-1:0] trigValue;
  logic [AB-1:0] preCount;
  logic [AB-1:0] postCount;
  logic          wrEn;
  logic [AB-1:0] wrAddr;
  logic [NC-1:0] wrData;
  logic [AB-1:0] trigAddr;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  capture_controller #(
    .NUM_CHANNELS(NC),
    .ADDR_BITS   (AB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .abort      (abort),
    .sampleTick (sampleTick),
    .chanSignals(chanSignals),
    .trigMask   (trigMask),
    .trigValue  (trigValue),
    .preCount   (preCount),
    .postCount  (postCount),
    .wrEn       (wrEn),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .trigAddr   (trigAddr),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          arm;
    logic          abort;
    logic          tick;
    logic [NC-1:0] chan;
    logic [NC-1:0] mask;
    logic [NC-1:0] value;
    logic [AB-1:0] pre;
    logic [AB-1:0] post;
    logic          en;
    logic [AB-1:0] addr;
    logic [NC-1:0] data;
    logic [AB-1:0] trig;
    logic [2:0]    st;
    logic          bsy;
    logic          dn;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic a, input logic ab, input logic t,
                              input logic [NC-1:0] c, input logic [NC-1:0] m,
                              input logic [NC-1:0] tv, input logic [AB-1:0] pr,
                              input logic [AB-1:0] po, input logic e,
                              input logic [AB-1:0] ad, input logic [NC-1:0] d,
                              input logic [AB-1:0] tg, input logic [2:0] st,
                              input logic b, input logic dn);
    vec_t r;
    r.arm = a;   r.abort = ab; r.tick = t;  r.chan = c;  r.mask = m;
    r.value = tv; r.pre = pr;  r.post = po; r.en = e;    r.addr = ad;
    r.data = d;  r.trig = tg;  r.st = st;   r.bsy = b;   r.dn = dn;
    return r;
  endfunction

  task automatic drive(input logic a, input logic ab, input logic t,
                       input logic [NC-1:0] c, input logic [NC-1:0] m,
                       input logic [NC-1:0] tv, input logic [AB-1:0] pr,
                       input logic [AB-1:0] po);
    arm = a; abort = ab; sampleTick = t; chanSignals = c;
    trigMask = m; trigValue = tv; preCount = pr; postCount = po;
  endtask

  task automatic chk(input string nm, input logic e, input logic [AB-1:0] ad,
                     input logic [NC-1:0] d, input logic [AB-1:0] tg,
                     input logic [2:0] st, input logic b, input logic dn);
    n_vec++;
    if (wrEn !== e || wrAddr !== ad || wrData !== d || trigAddr !== tg ||
        state !== st || busy !== b || done !== dn) begin
      n_bad++;
      $display("FAIL %s: got en=%0b addr=%0d data=%h trig=%0d state=%0d busy=%0b done=%0b; want en=%0b addr=%0d data=%h trig=%0d state=%0d busy=%0b done=%0b",
               nm, wrEn, wrAddr, wrData, trigAddr, state, busy, done,
               e, ad, d, tg, st, b, dn);
    end
  endtask

  // One vector: inputs set at the falling edge, outputs checked 1 after the rising edge.
  task automatic step(input string nm, input vec_t v);
    @(negedge clk);
    drive(v.arm, v.abort, v.tick, v.chan, v.mask, v.value, v.pre, v.post);
    @(posedge clk);
    #1;
    chk(nm, v.en, v.addr, v.data, v.trig, v.st, v.bsy, v.dn);
  endtask

  initial begin
    // Pre4/post3 with bit0 trigger on a counting input; odd pretrig samples must not trigger.
    tbl.push_back(mk(1,0,0,16'h0000,16'h0001,16'h0001,4,3, 0,0,16'h0000,0,1,1,0));
    tbl.push_back(mk(0,0,1,16'h0010,16'h0001,16'h0001,4,3, 1,0,16'h0010,0,1,1,0));
    tbl.push_back(mk(0,0,1,16'h0011,16'h0001,16'h0001,4,3, 1,1,16'h0011,0,1,1,0));
    tbl.push_back(mk(0,0,1,16'h0012,16'h0001,16'h0001,4,3, 1,2,16'h0012,0,1,1,0));
    tbl.push_back(mk(0,0,1,16'h0013,16'h0001,16'h0001,4,3, 1,3,16'h0013,0,2,1,0));
    tbl.push_back(mk(0,0,1,16'h0014,16'h0001,16'h0001,4,3, 1,4,16'h0014,0,2,1,0));
    tbl.push_back(mk(0,0,1,16'h0015,16'h0001,16'h0001,4,3, 1,5,16'h0015,5,3,1,0));
    tbl.push_back(mk(0,0,1,16'h0016,16'h0001,16'h0001,4,3, 1,6,16'h0016,5,3,1,0));
    tbl.push_back(mk(0,0,1,16'h0017,16'h0001,16'h0001,4,3, 1,7,16'h0017,5,3,1,0));
    tbl.push_back(mk(0,0,1,16'h0018,16'h0001,16'h0001,4,3, 1,0,16'h0018,5,4,0,1));
    tbl.push_back(mk(0,0,1,16'h0019,16'h0001,16'h0001,4,3, 0,0,16'h0018,5,4,0,1));
    // Pre0/post0, empty mask: first sample is the trigger and completes the capture.
    tbl.push_back(mk(1,0,0,16'h0000,16'h0000,16'h0000,0,0, 0,0,16'h0018,5,2,1,0));
    tbl.push_back(mk(0,0,1,16'h002A,16'h0000,16'h0000,0,0, 1,0,16'h002A,0,4,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,16'h0000,16'h0000,0,0, 0,0,16'h002A,0,4,0,1));
    // Tick every 4th cycle; a matching value on unsampled cycles must be ignored.
    tbl.push_back(mk(1,0,0,16'h0000,16'hFFFF,16'h00AA,1,1, 0,0,16'h002A,0,1,1,0));
    tbl.push_back(mk(0,0,1,16'h0001,16'hFFFF,16'h00AA,1,1, 1,0,16'h0001,0,2,1,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,16'h00AA,16'hFFFF,16'h00AA,1,1, 0,0,16'h0001,0,2,1,0));
    tbl.push_back(mk(0,0,1,16'h00AB,16'hFFFF,16'h00AA,1,1, 1,1,16'h00AB,0,2,1,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,16'h00AA,16'hFFFF,16'h00AA,1,1, 0,1,16'h00AB,0,2,1,0));
    tbl.push_back(mk(0,0,1,16'h00AA,16'hFFFF,16'h00AA,1,1, 1,2,16'h00AA,2,3,1,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,16'h00AA,16'hFFFF,16'h00AA,1,1, 0,2,16'h00AA,2,3,1,0));
    tbl.push_back(mk(0,0,1,16'h1234,16'hFFFF,16'h00AA,1,1, 1,3,16'h1234,2,4,0,1));
    // arm+abort in DONE goes to IDLE; ticks in IDLE never write.
    tbl.push_back(mk(1,1,1,16'h5555,16'hFFFF,16'h00AA,1,1, 0,3,16'h1234,2,0,0,0));
    tbl.push_back(mk(0,0,1,16'h7777,16'hFFFF,16'h00AA,1,1, 0,3,16'h1234,2,0,0,0));
    // Re-arm while busy ignored; abort with a tick in POSTTRIG drops the write.
    tbl.push_back(mk(1,0,0,16'h0000,16'h0001,16'h0000,0,2, 0,0,16'h1234,2,2,1,0));
    tbl.push_back(mk(1,0,1,16'h0003,16'h0001,16'h0000,5,2, 1,0,16'h0003,2,2,1,0));
    tbl.push_back(mk(0,0,1,16'h0002,16'h0001,16'h0000,0,2, 1,1,16'h0002,1,3,1,0));
    tbl.push_back(mk(0,1,1,16'h0004,16'h0001,16'h0000,0,2, 0,1,16'h0002,1,0,0,0));
    tbl.push_back(mk(0,0,1,16'h0008,16'h0001,16'h0000,0,2, 0,1,16'h0002,1,0,0,0));

    reset = 1'b1;
    drive(0,0,0,16'h0,16'h0,16'h0,0,0);
    #1;
    chk("reset_async", 0,0,16'h0,0,0,0,0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_idle", 0,0,16'h0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // Trigger never matches: address wraps 7->0 while staying in WAIT_TRIG.
    step("wrap_arm", mk(1,0,0,16'h0,16'hFFFF,16'hFFFF,0,0, 0,0,16'h0002,1,2,1,0));
    for (int i = 0; i < 20; i++)
      step($sformatf("wrap%0d", i),
           mk(0,0,1,NC'(i),16'hFFFF,16'hFFFF,0,0, 1,AB'(i % 8),NC'(i),1,2,1,0));
    step("wrap_abort", mk(0,1,1,16'h00FF,16'hFFFF,16'hFFFF,0,0, 0,3,16'h0013,1,0,0,0));

    // Reset between edges in the middle of POSTTRIG.
    step("rst_arm",   mk(1,0,0,16'h0,16'h0,16'h0,0,3, 0,0,16'h0013,1,2,1,0));
    step("rst_post0", mk(0,0,1,16'h0040,16'h0,16'h0,0,3, 1,0,16'h0040,0,3,1,0));
    step("rst_post1", mk(0,0,1,16'h0041,16'h0,16'h0,0,3, 1,1,16'h0041,0,3,1,0));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid", 0,0,16'h0,0,0,0,0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      step($sformatf("rst_quiet%0d", i), mk(0,0,1,16'h0050,16'h0,16'h0,0,3, 0,0,16'h0,0,0,0,0));
    step("rst_rearm", mk(1,0,0,16'h0,16'h0,16'h0,0,0, 0,0,16'h0,0,2,1,0));
    step("rst_write", mk(0,0,1,16'h0099,16'h0,16'h0,0,0, 1,0,16'h0099,0,4,0,1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
